clkgate_enable_ctrl: RTL

// - Generates the enable E for a downstream latch-based clock-gate cell (CK, E -> GCK) from domain

---
 rtl/clkgate_enable_ctrl_pkg.sv | 24 ++
 rtl/clkgate_enable_ctrl_sat_counter.sv | 32 +++
 rtl/clkgate_enable_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/clkgate_enable_ctrl_pkg.sv
// Shared types for the clock-gate enable controller: FSM encoding, reset state,
// and the output decode used to register E / clk_rdy from the next state.
package cg_pkg;

  typedef enum logic [1:0] {
    CG_ON   = 2'd0,
    CG_IDLE = 2'd1,
    CG_OFF  = 2'd2,
    CG_WAKE = 2'd3
  } cg_state_t;

  localparam cg_state_t CG_RST_STATE = CG_ON;

  // Gate cell is enabled in every state except OFF.
  function automatic logic cg_gate_open(input cg_state_t s);
    return (s != CG_OFF);
  endfunction

  // Gated clock is only guaranteed stable once the wake window has elapsed.
  function automatic logic cg_clk_ready(input cg_state_t s);
    return (s == CG_ON) || (s == CG_IDLE);
  endfunction

endpackage

// File: rtl/clkgate_enable_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together load 1.
module cg_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (inc_i && (cnt_d != '1)) begin
      cnt_d = cnt_d + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clkgate_enable_ctrl.sv
// Enable generator for a latch-based clock-gate cell: closes the gate after a
// programmable idle run and reopens it with a timed wake handshake.
module clkgate_enable_ctrl
  import cg_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2,
  parameter int STAT_W   = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              req,
  input  logic              busy,
  input  logic              force_on,
  input  logic [CNT_W-1:0]  idle_thresh,
  output logic              E,
  output logic              clk_rdy,
  output logic [STAT_W-1:0] gate_events
);

  localparam int WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

  cg_state_t          state_q, state_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [STAT_W-1:0]  gate_events_q, gate_events_d;
  logic               e_q, rdy_q;

  logic               act;
  logic               thresh_nz;
  logic               idle_clr, idle_inc;
  logic [CNT_W-1:0]   idle_cnt;

  assign act       = req | busy | force_on;
  assign thresh_nz = (idle_thresh != '0);

  cg_sat_counter #(
    .W (CNT_W)
  ) u_idle_cnt (
    .clk_i (CK),
    .rst_i (RST),
    .clr_i (idle_clr),
    .inc_i (idle_inc),
    .cnt_o (idle_cnt)
  );

  always_comb begin
    state_d       = state_q;
    wake_cnt_d    = wake_cnt_q;
    gate_events_d = gate_events_q;
    idle_clr      = 1'b0;
    idle_inc      = 1'b0;
    case (state_q)
      CG_ON: begin
        // Counter sits at zero in ON; entering IDLE loads it with 1.
        idle_clr = 1'b1;
        if (!act && thresh_nz) begin
          state_d  = CG_IDLE;
          idle_inc = 1'b1;
        end
      end
      CG_IDLE: begin
        // Activity beats the threshold compare; a zero threshold disables gating.
        if (act || !thresh_nz) begin
          state_d  = CG_ON;
          idle_clr = 1'b1;
        end else if (idle_cnt >= idle_thresh) begin
          state_d       = CG_OFF;
          gate_events_d = gate_events_q + STAT_W'(1);
        end else begin
          idle_inc = 1'b1;
        end
      end
      CG_OFF: begin
        if (act) begin
          state_d    = CG_WAKE;
          wake_cnt_d = '0;
        end
      end
      CG_WAKE: begin
        wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        if (wake_cnt_q == WAKE_LAST) begin
          state_d  = CG_ON;
          idle_clr = 1'b1;
        end
      end
      default: begin
        state_d  = CG_RST_STATE;
        idle_clr = 1'b1;
      end
    endcase
  end

  // E and clk_rdy are decoded from the next state so they align with the state flop.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q       <= CG_RST_STATE;
      wake_cnt_q    <= '0;
      gate_events_q <= '0;
      e_q           <= 1'b1;
      rdy_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      wake_cnt_q    <= wake_cnt_d;
      gate_events_q <= gate_events_d;
      e_q           <= cg_gate_open(state_d);
      rdy_q         <= cg_clk_ready(state_d);
    end
  end

  assign E           = e_q;
  assign clk_rdy     = rdy_q;
  assign gate_events = gate_events_q;

endmodule
